// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge generator: FSM states, edge-mode codes
// and the mapping from a mode to its idle/active output level.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] EDGE_FALL = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  function automatic logic is_toggle(input logic [1:0] mode);
    return (mode & EDGE_BOTH) != 2'b00;
  endfunction

  // Toggle modes have no fixed idle level, so they keep whatever is driven now.
  function automatic logic idle_level(input logic [1:0] mode, input logic current);
    return is_toggle(mode) ? current : (mode == EDGE_FALL);
  endfunction

  function automatic logic active_level(input logic [1:0] mode, input logic current);
    return is_toggle(mode) ? ~current : (mode == EDGE_RISE);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that measures one hold window; done is high while the
// count sits at zero, and the count never wraps below zero.
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_value;
      end else if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/edge_generator.sv
// Turns single-cycle trigger events into level waveforms that a matching edge
// detector sees as exactly one edge/pulse per accepted trigger.
module edge_generator
  import edge_pkg::*;
#(
  parameter  int CNT_W       = 8,
  parameter  int MAX_PENDING = 3,
  localparam int PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              trigger,
  input  logic [1:0]        select_edge,
  input  logic [CNT_W-1:0]  hold_cycles,
  output logic              data_out,
  output logic              busy,
  output logic              drop,
  output logic [PEND_W-1:0] pending_cnt
);

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] hold_q;

  logic             timer_done;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic [CNT_W-1:0] load_now;
  logic             mode_change;
  logic             start;
  logic             accept;
  logic [PEND_W-1:0] pend_after_trig;

  always_comb begin
    // hold_q and the timer both store W-1, so W=0 and W=1 share a reload of 0
    load_now        = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
    mode_change     = (select_edge != mode_q);
    start           = (pending_cnt != '0) || trigger;
    accept          = trigger && (pending_cnt < PEND_W'(MAX_PENDING));
    pend_after_trig = accept ? pending_cnt + 1'b1 : pending_cnt;

    timer_load  = 1'b0;
    timer_value = hold_q;
    if (enable) begin
      case (state)
        IDLE: begin
          if (mode_change || start) begin
            timer_load  = 1'b1;
            timer_value = load_now;
          end
        end
        ACTIVE: begin
          if (timer_done && !is_toggle(mode_q)) begin
            timer_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (enable),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= EDGE_RISE;
      hold_q      <= '0;
      data_out    <= 1'b0;
      busy        <= 1'b0;
      drop        <= 1'b0;
      pending_cnt <= '0;
    end else if (!enable) begin
      drop <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_change) begin
            // A trigger coinciding with a mode switch is queued, not lost
            mode_q      <= select_edge;
            hold_q      <= load_now;
            data_out    <= idle_level(select_edge, data_out);
            state       <= RECOVER;
            busy        <= 1'b1;
            pending_cnt <= pend_after_trig;
            drop        <= trigger && !accept;
          end else if (start) begin
            hold_q   <= load_now;
            data_out <= active_level(mode_q, data_out);
            state    <= ACTIVE;
            busy     <= 1'b1;
            if (pending_cnt != '0 && !trigger) begin
              pending_cnt <= pending_cnt - 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ACTIVE: begin
          pending_cnt <= pend_after_trig;
          drop        <= trigger && !accept;
          if (timer_done) begin
            if (is_toggle(mode_q)) begin
              state <= IDLE;
              busy  <= (pend_after_trig != '0);
            end else begin
              state    <= RECOVER;
              data_out <= idle_level(mode_q, data_out);
            end
          end
        end
        RECOVER: begin
          pending_cnt <= pend_after_trig;
          drop        <= trigger && !accept;
          if (timer_done) begin
            state <= IDLE;
            busy  <= (pend_after_trig != '0);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_generator.sv
// Self-checking bench for edge_generator: directed scenarios plus a random run,
// all compared cycle by cycle against a phase/remaining-cycles reference model.
module tb_edge_generator;

  localparam int CNT_W       = 8;
  localparam int MAX_PENDING = 3;
  localparam int PEND_W      = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              trigger = 1'b0;
  logic [1:0]        select_edge = 2'b01;
  logic [CNT_W-1:0]  hold_cycles = 8'd3;
  logic              data_out;
  logic              busy;
  logic              drop;
  logic [PEND_W-1:0] pending_cnt;

  edge_generator #(
    .CNT_W      (CNT_W),
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .trigger    (trigger),
    .select_edge(select_edge),
    .hold_cycles(hold_cycles),
    .data_out   (data_out),
    .busy       (busy),
    .drop       (drop),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 active, 2 recover; rem = cycles left in phase
  int         m_phase, m_rem, m_wl, m_pend;
  logic [1:0] m_mode;
  bit         m_level, m_drop;

  // Observation statistics for the directed scenarios
  int rises, falls, edges, peak, drops, hi_en, hi_dis;
  bit prev_dout;

  task automatic clear_counts();
    rises = 0; falls = 0; edges = 0; peak = 0; drops = 0; hi_en = 0; hi_dis = 0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_wl = 1; m_pend = 0;
    m_mode = 2'b01; m_level = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_queue();
    if (trigger) begin
      if (m_pend < MAX_PENDING) m_pend++;
      else m_drop = 1'b1;
    end
  endtask

  task automatic model_step();
    int w;
    w = (hold_cycles == 0) ? 1 : int'(hold_cycles);
    m_drop = 1'b0;
    if (!enable) return;
    if (m_phase == 0) begin
      if (select_edge != m_mode) begin
        m_mode = select_edge;
        if (m_mode == 2'b00) m_level = 1'b1;
        else if (m_mode == 2'b01) m_level = 1'b0;
        m_phase = 2; m_rem = w; m_wl = w;
        model_queue();
      end else if (m_pend > 0 || trigger) begin
        if (m_pend > 0 && !trigger) m_pend--;
        m_phase = 1; m_rem = w; m_wl = w;
        m_level = m_mode[1] ? !m_level : (m_mode == 2'b01);
      end
    end else begin
      model_queue();
      m_rem--;
      if (m_rem == 0) begin
        if (m_phase == 1 && !m_mode[1]) begin
          m_phase = 2; m_rem = m_wl; m_level = (m_mode == 2'b00);
        end else begin
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic step(input bit trg);
    trigger = trg;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check("data_out", data_out, m_level);
    check("busy", busy, (m_phase != 0 || m_pend != 0));
    check("drop", drop, m_drop);
    check("pending_cnt", pending_cnt, m_pend);
    if (data_out !== prev_dout) begin
      edges++;
      if (data_out) rises++; else falls++;
    end
    prev_dout = data_out;
    if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
    if (drop) drops++;
    if (data_out && enable) hi_en++;
    if (data_out && !enable) hi_dis++;
    trigger = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    check("rst_pending", pending_cnt, 0);
    prev_dout = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [5:0] seq;

  initial begin
    model_reset();
    clear_counts();
    prev_dout = 1'b0;

    // 1: rise mode, W=3, single trigger
    do_reset();
    enable = 1'b1; select_edge = 2'b01; hold_cycles = 8'd3;
    step(0); step(0);
    clear_counts();
    step(1);
    seq = {5'b0, data_out};
    for (int i = 0; i < 5; i++) begin
      step(0);
      seq = {seq[4:0], data_out};
    end
    step(0);
    check("s1_seq", seq, 6'b111000);
    check("s1_busy_after", busy, 0);
    check("s1_pulses", rises, 1);

    // 2: switch to fall mode, recover window, then one low pulse
    clear_counts();
    select_edge = 2'b00;
    for (int i = 0; i < 4; i++) step(0);
    step(1);
    for (int i = 0; i < 8; i++) step(0);
    check("s2_fall_pulses", falls, 1);
    check("s2_idle_high", data_out, 1);

    // 3: toggle mode, W=1, five triggers spaced four cycles
    do_reset();
    clear_counts();
    select_edge = 2'b10; hold_cycles = 8'd1;
    for (int i = 0; i < 3; i++) step(0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      for (int i = 0; i < 3; i++) step(0);
    end
    check("s3_edges", edges, 5);
    check("s3_final", data_out, 1);

    // 4: W=4, six back-to-back triggers saturate the queue
    do_reset();
    select_edge = 2'b01; hold_cycles = 8'd4;
    step(0);
    clear_counts();
    for (int i = 0; i < 6; i++) step(1);
    for (int i = 0; i < 40; i++) step(0);
    check("s4_peak", peak, 3);
    check("s4_drops", drops, 2);
    check("s4_pulses", rises, 4);
    check("s4_busy_end", busy, 0);

    // 5: enable low for 7 cycles mid-ACTIVE, W=5
    do_reset();
    select_edge = 2'b01; hold_cycles = 8'd5;
    step(0);
    clear_counts();
    step(1); step(0); step(0);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) step(0);
    enable = 1'b1;
    for (int i = 0; i < 14; i++) step(0);
    check("s5_active_enabled", hi_en, 5);
    check("s5_frozen_high", hi_dis, 7);

    // 6: reset mid-RECOVER with two queued triggers
    do_reset();
    select_edge = 2'b01; hold_cycles = 8'd4;
    step(0);
    step(1); step(1); step(1);
    step(0); step(0); step(0);
    check("s6_pending_before", pending_cnt, 2);
    do_reset();
    clear_counts();
    for (int i = 0; i < 20; i++) step(0);
    check("s6_no_pulses", rises, 0);

    // 7: randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      enable = ($urandom % 10) != 0;
      if ($urandom % 50 == 0) begin
        select_edge = 2'($urandom_range(0, 3));
        hold_cycles = 8'($urandom_range(0, 4));
      end
      if ($urandom % 300 == 0) do_reset();
      step(($urandom % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_generator.md
# edge_generator

Event-to-waveform generator for the button path: converts single-cycle `trigger` events into level transitions on `data_out`, shaped so that an edge detector configured with the same `select_edge` code emits exactly one pulse per accepted trigger. Used for stimulus injection and for regenerating button levels from event streams. Triggers arriving while an event is in progress are queued in a bounded pending counter. Triggers beyond that bound are dropped and flagged.

## Interface
- `CNT_W`, 8, width of `hold_cycles` and the internal hold timer
- `MAX_PENDING`, 3, maximum queued triggers (≥1); `PEND_W` = `$clog2(MAX_PENDING+1)` derived
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `enable` input 1 — 0 freezes all state; triggers ignored, outputs held
- `trigger` input 1 — event request, sampled when `enable`=1
- `select_edge` input 2 — 00 falling pulse (idle high), 01 rising pulse (idle low), 10/11 toggle
- `hold_cycles` input `CNT_W` — hold length W in cycles; 0 treated as 1
- `data_out` output 1 — generated level
- `busy` output 1 — state≠IDLE or pending≠0
- `drop` output 1 — one-cycle pulse when a trigger is discarded
- `pending_cnt` output `PEND_W` — queued trigger count

## Operation
- Reset values: `data_out`=0, `busy`=0, `drop`=0, `pending_cnt`=0, state IDLE, latched mode `mode_q`=01.
- FSM states: IDLE, ACTIVE, RECOVER. `mode_q` and W are latched on entry to ACTIVE or RECOVER. Changes during an event take effect only at the next IDLE decision.
- IDLE priority (enable=1):
  1. `select_edge`≠`mode_q`: latch the new mode. Pulse modes drive the new idle level (00→1, 01→0); toggle keeps the current level. Enter RECOVER for W cycles.
  2. Else, if pending>0 or trigger: start an event and enter ACTIVE. Pending decrements when >0. A trigger in the same cycle is the one started when pending=0, or is queued otherwise, so the net count is unchanged.
- ACTIVE, pulse modes: drive the active level (00→0, 01→1) for W cycles, then RECOVER.
- ACTIVE, toggle mode: invert `data_out` on entry, hold W cycles, then IDLE (no RECOVER).
- RECOVER: drive the idle level for W cycles, then IDLE.
- Triggers outside IDLE: pending increments if <`MAX_PENDING`; otherwise `drop`=1 for one cycle and the count is unchanged.
- `enable`=0 mid-event: timer, state, and pending hold. The event resumes on re-enable with no extra or lost cycles.
- `rst_n` asserted mid-event: immediate return to reset values; queued triggers are lost.

## Timing
- All outputs are registered.
- Trigger at cycle t with IDLE, pending=0, W=N, pulse mode: `data_out` at active level for cycles t+1..t+N, idle for t+N+1..t+2N. IDLE decision at t+2N+1; the next queued event changes `data_out` at t+2N+2.
- Toggle mode: edge at t+1, IDLE decision at t+N+1.
- `busy` rises at t+1 and falls the cycle after the last event's final hold cycle when pending=0.
- `drop` is asserted the cycle after the rejected trigger.
- Hold timer is a down-counter loaded with max(W,1)−1 and expires at 0. No wrap; W=2^CNT_W−1 is legal.

## Structure
- Shared package `edge_pkg`:
  - state enum (IDLE/ACTIVE/RECOVER)
  - mode constants `EDGE_FALL`=2'b00, `EDGE_RISE`=2'b01, `EDGE_BOTH`=2'b1x
  - function mapping mode to idle level
- Natural sub-module: `hold_timer`, a loadable `CNT_W` down-counter with enable and a `done` flag. The FSM and pending counter stay in `edge_generator`.

## Test plan
- After reset, `select_edge`=01, W=3, one trigger: `data_out` high exactly cycles t+1..t+3, low t+4..t+6; `busy` deasserts afterwards; downstream detector mode 01 counts 1 pulse.
- `select_edge`=00 after reset: `data_out` rises (mode change), 1 recover window, then a trigger gives a 3-cycle low pulse; detector mode 00 counts 1.
- Toggle mode, W=1, 5 triggers spaced 4 cycles: 5 edges; `data_out` ends at 1; detector mode 10 counts 5.
- MAX_PENDING=3, W=4, 6 back-to-back triggers: `pending_cnt` peaks at 3; `drop` pulses twice; exactly 4 pulses generated.
- `enable` low for 7 cycles mid-ACTIVE with W=5: active phase lasts 5 enabled cycles total; `data_out` frozen while disabled.
- `rst_n` low mid-RECOVER with pending=2: all outputs return to reset values immediately; no pulses follow release.
